uart_tx_param: RTL and testbench
================================

// Module: uart_tx_param
// PURPOSE
//   Parametrised UART serial transmitter, next generation of the 7-bit fixed-rate uart_ctrl.
//   Adds configurable data width, optional parity, 1/2 stop bits and an internal baud divider.
//   Keeps the four-phase trx_req/trx_ack handshake towards the host logic.
//   Drives the board's serial TX line directly.
// PARAMETERS
//   DATA_BITS     8    data bits per frame, legal 5..9, sent LSB first
//   PARITY        0    0 = none, 1 = odd, 2 = even
//   STOP_BITS     1    stop bits per frame, legal 1 or 2
//   CLKS_PER_BIT  16   clk cycles per serial bit, >= 1 (1 = uart_ctrl-style bit-per-clock)
// PORTS
//   clk      in   1          system clock; all state updates on the falling edge (as uart_ctrl)
//   clr_n    in   1          reset, synchronous, active-low
//   wr       in   DATA_BITS  byte to send; sampled only on frame start
//   trx_req  in   1          host request; level, four-phase
//   trx_ack  out  1          frame done; held until trx_req drops
//   trx      out  1          serial line, idle high
//   busy     out  1          high from frame start until return to IDLE
// BEHAVIOUR
//   Reset (clr_n=0 at an active edge): state IDLE, trx=1, trx_ack=0, busy=0, bit/baud counters 0.
//   Reset mid-frame aborts the frame immediately; trx returns to 1 on that edge.
//   States: IDLE, START, DATA, PAR, STOP, ACK.
//   IDLE: trx=1. An edge that samples trx_req=1 latches wr into shift reg, trx<=0, busy<=1, -> START.
//   Each bit is held exactly CLKS_PER_BIT cycles; baud counter 0..CLKS_PER_BIT-1, wraps on tick.
//   START -> DATA: trx <= data[0]; DATA shifts LSB first, DATA_BITS bits.
//   After last data bit -> PAR if PARITY!=0, else STOP.
//   Parity bit: even = ^data, odd = ~^data (computed from latched data).
//   STOP: trx=1 for STOP_BITS*CLKS_PER_BIT cycles.
//   End of STOP: if trx_req=1 -> ACK, trx_ack<=1. If trx_req=0 -> IDLE directly, no ack, busy<=0.
//   ACK: trx=1; on edge sampling trx_req=0 -> trx_ack<=0, busy<=0, IDLE.
//   A new frame cannot start before trx_req has been seen low (no back-to-back without handshake).
//   Frame length = (1 + DATA_BITS + (PARITY?1:0) + STOP_BITS) * CLKS_PER_BIT cycles,
//     from the start edge to the ack edge.
//   trx_req dropping mid-frame does NOT abort; the frame completes (uart_ctrl aborted; changed).
//   wr changes during a frame are ignored.
//   Counters: baud width $clog2(CLKS_PER_BIT) min 1; bit counter width $clog2(DATA_BITS+1).
//   Illegal parameter values: elaboration-time $error.
// STRUCTURE
//   uart_pkg: parity mode constants (PAR_NONE/PAR_ODD/PAR_EVEN), tx state enum.
//     Shared with the future receiver.
//   Sub-module uart_baud_gen: CLKS_PER_BIT counter with clear and one-cycle tick output.
//     Reused by the RX block.
//   Top: state machine, shift register, parity generation, handshake.
// TESTING
//   DATA_BITS=8, PARITY=0, STOP_BITS=1, CLKS_PER_BIT=4; wr=8'hA5, req held.
//     -> trx bits 0,1,0,1,0,0,1,0,1,1, each 4 clks.
//     -> trx_ack high at cycle 40; drop req -> ack low next edge, busy low.
//   PARITY=2, wr=8'h07 -> parity bit 1.
//   PARITY=1, wr=8'h07 -> parity bit 0.
//   Either parity: frame is 11 bits (44 clks).
//   STOP_BITS=2, DATA_BITS=7, CLKS_PER_BIT=1, wr=7'h41.
//     -> 0,1,0,0,0,0,0,1,1,1 on consecutive edges; ack on the 10th edge.
//   Drop req at data bit 3; change wr mid-frame.
//     -> frame still completes with the original byte; no ack; IDLE; busy=0.
//   Assert clr_n=0 during DATA.
//     -> same edge: trx=1, trx_ack=0, busy=0.
//     -> with req held high after release, a fresh start bit follows.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: parity modes and transmitter state encoding.
// The receiver uses the same parity constants.
package uart_pkg;

  // Parity modes
  localparam int unsigned PAR_NONE = 0;
  localparam int unsigned PAR_ODD  = 1;
  localparam int unsigned PAR_EVEN = 2;

  // Transmitter states
  localparam logic [2:0] TX_IDLE  = 3'd0;
  localparam logic [2:0] TX_START = 3'd1;
  localparam logic [2:0] TX_DATA  = 3'd2;
  localparam logic [2:0] TX_PAR   = 3'd3;
  localparam logic [2:0] TX_STOP  = 3'd4;
  localparam logic [2:0] TX_ACK   = 3'd5;

endpackage

// File: rtl/uart_baud_gen.sv
// Baud divider: counts 0..CLKS_PER_BIT-1 and pulses tick on the last count.
// While clr is high the counter is parked at 0, so the first tick after
// clr drops arrives exactly CLKS_PER_BIT cycles later.
module uart_baud_gen #(
  parameter int unsigned CLKS_PER_BIT = 16
) (
  input  logic clk,
  input  logic clr_n,
  input  logic clr,
  output logic tick
);

  localparam int unsigned BW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [BW-1:0] LAST = BW'(CLKS_PER_BIT - 1);

  logic [BW-1:0] cnt_q;

  assign tick = !clr && (cnt_q == LAST);

  // Counter register, falling-edge clocked like the transmitter
  always_ff @(negedge clk) begin
    if (!clr_n || clr) begin
      cnt_q <= '0;
    end else if (tick) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + BW'(1);
    end
  end

endmodule

// File: rtl/uart_tx_param.sv
// Parametrised UART transmitter with four-phase trx_req/trx_ack handshake.
// All state changes on the falling clock edge; clr_n is a synchronous reset.
// Frame: start bit, DATA_BITS data bits LSB first, optional parity, stop bits.
module uart_tx_param
  import uart_pkg::*;
#(
  parameter int unsigned DATA_BITS    = 8,
  parameter int unsigned PARITY       = 0,
  parameter int unsigned STOP_BITS    = 1,
  parameter int unsigned CLKS_PER_BIT = 16
) (
  input  logic                 clk,
  input  logic                 clr_n,
  input  logic [DATA_BITS-1:0] wr,
  input  logic                 trx_req,
  output logic                 trx_ack,
  output logic                 trx,
  output logic                 busy
);

  if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data_bits
    $error("uart_tx_param: DATA_BITS must be 5..9");
  end
  if (PARITY > 2) begin : g_bad_parity
    $error("uart_tx_param: PARITY must be 0, 1 or 2");
  end
  if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop_bits
    $error("uart_tx_param: STOP_BITS must be 1 or 2");
  end
  if (CLKS_PER_BIT < 1) begin : g_bad_clks
    $error("uart_tx_param: CLKS_PER_BIT must be >= 1");
  end

  localparam int unsigned CW = $clog2(DATA_BITS + 1);
  localparam logic [CW-1:0] LAST_DATA = CW'(DATA_BITS - 1);
  localparam logic [CW-1:0] LAST_STOP = CW'(STOP_BITS - 1);

  logic [2:0]           state_q, state_d;
  logic [DATA_BITS-1:0] data_q, data_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [CW-1:0]        bit_cnt_q, bit_cnt_d;
  logic                 trx_q, trx_d;
  logic                 ack_q, ack_d;
  logic                 busy_q, busy_d;
  logic                 tick;
  logic                 baud_clr;
  logic                 par_bit;

  // Baud counter only runs while a bit is actually on the line
  assign baud_clr = (state_q == TX_IDLE) || (state_q == TX_ACK);

  uart_baud_gen #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud (
    .clk  (clk),
    .clr_n(clr_n),
    .clr  (baud_clr),
    .tick (tick)
  );

  // Parity is taken from the latched word, not the shifting copy
  assign par_bit = (PARITY == PAR_EVEN) ? ^data_q : ~^data_q;

  // Next-state logic: one transition per baud tick, handshake in IDLE/STOP/ACK
  always_comb begin
    state_d   = state_q;
    data_d    = data_q;
    shift_d   = shift_q;
    bit_cnt_d = bit_cnt_q;
    trx_d     = trx_q;
    ack_d     = ack_q;
    busy_d    = busy_q;
    case (state_q)
      TX_IDLE: begin
        trx_d = 1'b1;
        if (trx_req) begin
          data_d  = wr;
          shift_d = wr;
          trx_d   = 1'b0;
          busy_d  = 1'b1;
          state_d = TX_START;
        end
      end
      TX_START: begin
        if (tick) begin
          trx_d     = shift_q[0];
          shift_d   = shift_q >> 1;
          bit_cnt_d = '0;
          state_d   = TX_DATA;
        end
      end
      TX_DATA: begin
        if (tick) begin
          if (bit_cnt_q == LAST_DATA) begin
            bit_cnt_d = '0;
            if (PARITY != PAR_NONE) begin
              trx_d   = par_bit;
              state_d = TX_PAR;
            end else begin
              trx_d   = 1'b1;
              state_d = TX_STOP;
            end
          end else begin
            trx_d     = shift_q[0];
            shift_d   = shift_q >> 1;
            bit_cnt_d = bit_cnt_q + CW'(1);
          end
        end
      end
      TX_PAR: begin
        if (tick) begin
          trx_d     = 1'b1;
          bit_cnt_d = '0;
          state_d   = TX_STOP;
        end
      end
      TX_STOP: begin
        if (tick) begin
          if (bit_cnt_q == LAST_STOP) begin
            bit_cnt_d = '0;
            // A host that already released req gets no ack
            if (trx_req) begin
              ack_d   = 1'b1;
              state_d = TX_ACK;
            end else begin
              busy_d  = 1'b0;
              state_d = TX_IDLE;
            end
          end else begin
            bit_cnt_d = bit_cnt_q + CW'(1);
          end
        end
      end
      TX_ACK: begin
        trx_d = 1'b1;
        if (!trx_req) begin
          ack_d   = 1'b0;
          busy_d  = 1'b0;
          state_d = TX_IDLE;
        end
      end
      default: begin
        trx_d   = 1'b1;
        ack_d   = 1'b0;
        busy_d  = 1'b0;
        state_d = TX_IDLE;
      end
    endcase
  end

  // State registers; reset aborts any frame on the same edge
  always_ff @(negedge clk) begin
    if (!clr_n) begin
      state_q   <= TX_IDLE;
      data_q    <= '0;
      shift_q   <= '0;
      bit_cnt_q <= '0;
      trx_q     <= 1'b1;
      ack_q     <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      data_q    <= data_d;
      shift_q   <= shift_d;
      bit_cnt_q <= bit_cnt_d;
      trx_q     <= trx_d;
      ack_q     <= ack_d;
      busy_q    <= busy_d;
    end
  end

  assign trx     = trx_q;
  assign trx_ack = ack_q;
  assign busy    = busy_q;

endmodule

// File: tb/tb_uart_tx_param.sv
// Bench for uart_tx_param: four configurations side by side, expected line
// bits queued from a small frame model and compared once per clock.
module tb_uart_tx_param;

  logic clk;
  logic clr_n;

  logic [7:0] wr_a, wr_e, wr_o;
  logic [6:0] wr_s;
  logic req_a, req_e, req_o, req_s;
  logic ack_a, ack_e, ack_o, ack_s;
  logic trx_a, trx_e, trx_o, trx_s;
  logic busy_a, busy_e, busy_o, busy_s;

  int total = 0;
  int bad = 0;
  logic exp_q[$];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  uart_tx_param #(.DATA_BITS(8), .PARITY(0), .STOP_BITS(1), .CLKS_PER_BIT(4)) dut_a (
    .clk(clk), .clr_n(clr_n), .wr(wr_a), .trx_req(req_a),
    .trx_ack(ack_a), .trx(trx_a), .busy(busy_a)
  );
  uart_tx_param #(.DATA_BITS(8), .PARITY(2), .STOP_BITS(1), .CLKS_PER_BIT(4)) dut_e (
    .clk(clk), .clr_n(clr_n), .wr(wr_e), .trx_req(req_e),
    .trx_ack(ack_e), .trx(trx_e), .busy(busy_e)
  );
  uart_tx_param #(.DATA_BITS(8), .PARITY(1), .STOP_BITS(1), .CLKS_PER_BIT(4)) dut_o (
    .clk(clk), .clr_n(clr_n), .wr(wr_o), .trx_req(req_o),
    .trx_ack(ack_o), .trx(trx_o), .busy(busy_o)
  );
  uart_tx_param #(.DATA_BITS(7), .PARITY(0), .STOP_BITS(2), .CLKS_PER_BIT(1)) dut_s (
    .clk(clk), .clr_n(clr_n), .wr(wr_s), .trx_req(req_s),
    .trx_ack(ack_s), .trx(trx_s), .busy(busy_s)
  );

  function automatic logic get_trx(input int idx);
    case (idx)
      0: return trx_a;
      1: return trx_e;
      2: return trx_o;
      default: return trx_s;
    endcase
  endfunction

  function automatic logic get_ack(input int idx);
    case (idx)
      0: return ack_a;
      1: return ack_e;
      2: return ack_o;
      default: return ack_s;
    endcase
  endfunction

  function automatic logic get_busy(input int idx);
    case (idx)
      0: return busy_a;
      1: return busy_e;
      2: return busy_o;
      default: return busy_s;
    endcase
  endfunction

  task automatic set_req(input int idx, input logic v);
    case (idx)
      0: req_a = v;
      1: req_e = v;
      2: req_o = v;
      default: req_s = v;
    endcase
  endtask

  task automatic set_wr(input int idx, input logic [8:0] v);
    case (idx)
      0: wr_a = v[7:0];
      1: wr_e = v[7:0];
      2: wr_o = v[7:0];
      default: wr_s = v[6:0];
    endcase
  endtask

  // Frame model: start, data LSB first, parity (odd=1 / even=2), stop bits
  task automatic push_frame(input logic [8:0] data, input int nbits, input int parity,
                            input int stops);
    int ones;
    ones = 0;
    exp_q.push_back(1'b0);
    for (int i = 0; i < nbits; i++) begin
      exp_q.push_back(data[i]);
      if (data[i]) ones++;
    end
    if (parity == 2) exp_q.push_back((ones % 2) == 1);
    if (parity == 1) exp_q.push_back((ones % 2) == 0);
    for (int i = 0; i < stops; i++) exp_q.push_back(1'b1);
  endtask

  // Sends one frame and checks every cycle of it, then the handshake tail.
  // drop_bit >= 0: at that bit index req is dropped and wr is changed.
  task automatic run_frame(input string name, input int idx, input logic [8:0] data,
                           input int nbits, input int parity, input int stops,
                           input int cpb, input int drop_bit, input logic [8:0] new_wr);
    logic exp_bit;
    int bit_i;
    push_frame(data, nbits, parity, stops);
    @(posedge clk);
    set_wr(idx, data);
    set_req(idx, 1'b1);
    bit_i = 0;
    while (exp_q.size() > 0) begin
      exp_bit = exp_q.pop_front();
      for (int c = 0; c < cpb; c++) begin
        @(posedge clk);
        total++;
        if (get_trx(idx) !== exp_bit || get_busy(idx) !== 1'b1 || get_ack(idx) !== 1'b0) begin
          bad++;
          $display("FAIL %s bit%0d cyc%0d: trx=%b busy=%b ack=%b, want trx=%b busy=1 ack=0",
                   name, bit_i, c, get_trx(idx), get_busy(idx), get_ack(idx), exp_bit);
        end
        if (bit_i == drop_bit && c == 0) begin
          set_req(idx, 1'b0);
          set_wr(idx, new_wr);
        end
      end
      bit_i++;
    end
    @(posedge clk);
    total++;
    if (drop_bit >= 0) begin
      if (get_ack(idx) !== 1'b0 || get_busy(idx) !== 1'b0 || get_trx(idx) !== 1'b1) begin
        bad++;
        $display("FAIL %s end_noack: ack=%b busy=%b trx=%b, want 0 0 1",
                 name, get_ack(idx), get_busy(idx), get_trx(idx));
      end
    end else begin
      if (get_ack(idx) !== 1'b1 || get_busy(idx) !== 1'b1 || get_trx(idx) !== 1'b1) begin
        bad++;
        $display("FAIL %s ack_rise: ack=%b busy=%b trx=%b, want 1 1 1",
                 name, get_ack(idx), get_busy(idx), get_trx(idx));
      end
    end
    set_req(idx, 1'b0);
    @(posedge clk);
    total++;
    if (get_ack(idx) !== 1'b0 || get_busy(idx) !== 1'b0 || get_trx(idx) !== 1'b1) begin
      bad++;
      $display("FAIL %s ack_fall: ack=%b busy=%b trx=%b, want 0 0 1",
               name, get_ack(idx), get_busy(idx), get_trx(idx));
    end
  endtask

  task automatic test_reset();
    clr_n = 1'b0;
    repeat (3) @(posedge clk);
    for (int i = 0; i < 4; i++) begin
      total++;
      if (get_trx(i) !== 1'b1 || get_ack(i) !== 1'b0 || get_busy(i) !== 1'b0) begin
        bad++;
        $display("FAIL reset dut%0d: trx=%b ack=%b busy=%b, want 1 0 0",
                 i, get_trx(i), get_ack(i), get_busy(i));
      end
    end
    clr_n = 1'b1;
    repeat (3) @(posedge clk);
    for (int i = 0; i < 4; i++) begin
      total++;
      if (get_trx(i) !== 1'b1 || get_busy(i) !== 1'b0) begin
        bad++;
        $display("FAIL idle dut%0d: trx=%b busy=%b, want 1 0", i, get_trx(i), get_busy(i));
      end
    end
  endtask

  task automatic test_basic();
    run_frame("basic_a5", 0, 9'h0A5, 8, 0, 1, 4, -1, 9'h000);
    run_frame("basic_3c", 0, 9'h03C, 8, 0, 1, 4, -1, 9'h000);
  endtask

  task automatic test_parity();
    run_frame("even_07", 1, 9'h007, 8, 2, 1, 4, -1, 9'h000);
    run_frame("odd_07", 2, 9'h007, 8, 1, 1, 4, -1, 9'h000);
    run_frame("even_c3", 1, 9'h0C3, 8, 2, 1, 4, -1, 9'h000);
  endtask

  task automatic test_two_stop();
    run_frame("stop2_41", 3, 9'h041, 7, 0, 2, 1, -1, 9'h000);
    run_frame("stop2_7f", 3, 9'h07F, 7, 0, 2, 1, -1, 9'h000);
  endtask

  task automatic test_drop_req();
    // bit index 4 is data bit 3
    run_frame("drop_req", 0, 9'h05A, 8, 0, 1, 4, 4, 9'h0FF);
    run_frame("drop_req7", 3, 9'h015, 7, 0, 2, 1, 4, 9'h06A);
  endtask

  task automatic test_reset_mid();
    @(posedge clk);
    set_wr(0, 9'h000);
    req_a = 1'b1;
    // 13 samples in: data bit 2 is on the line (a 0)
    repeat (13) @(posedge clk);
    clr_n = 1'b0;
    @(posedge clk);
    total++;
    if (trx_a !== 1'b1 || ack_a !== 1'b0 || busy_a !== 1'b0) begin
      bad++;
      $display("FAIL reset_mid: trx=%b ack=%b busy=%b, want 1 0 0", trx_a, ack_a, busy_a);
    end
    clr_n = 1'b1;
    @(posedge clk);
    total++;
    if (trx_a !== 1'b0 || busy_a !== 1'b1) begin
      bad++;
      $display("FAIL restart: trx=%b busy=%b, want 0 1", trx_a, busy_a);
    end
    req_a = 1'b0;
    repeat (45) @(posedge clk);
    total++;
    if (trx_a !== 1'b1 || busy_a !== 1'b0 || ack_a !== 1'b0) begin
      bad++;
      $display("FAIL restart_done: trx=%b busy=%b ack=%b, want 1 0 0", trx_a, busy_a, ack_a);
    end
  endtask

  initial begin
    clr_n = 1'b0;
    req_a = 1'b0; req_e = 1'b0; req_o = 1'b0; req_s = 1'b0;
    wr_a = '0; wr_e = '0; wr_o = '0; wr_s = '0;
    test_reset();
    test_basic();
    test_parity();
    test_two_stop();
    test_drop_req();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
